// File: rtl/fpnew_pipe_stages.sv
// Elastic result pipeline: NumPipeRegs valid/ready register stages carrying
// result, status flags and tag, with flush and busy indication.
module fpnew_pipe_stages #(
   parameter int unsigned Width       = 64,
   parameter int unsigned NumPipeRegs = 1,
   parameter int unsigned TagWidth    = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [Width-1:0]    in_result_i,
   input  logic [4:0]          in_status_i,
   input  logic [TagWidth-1:0] in_tag_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   output logic [Width-1:0]    out_result_o,
   output logic [4:0]          out_status_o,
   output logic [TagWidth-1:0] out_tag_o,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   input  logic                flush_i,
   output logic                busy_o
);

   if (NumPipeRegs == 0) begin : g_bypass
      logic unused_s;

      assign out_result_o = in_result_i;
      assign out_status_o = in_status_i;
      assign out_tag_o    = in_tag_i;
      assign out_valid_o  = in_valid_i;
      assign in_ready_o   = out_ready_i;
      assign busy_o       = 1'b0;
      assign unused_s     = clk_i ^ rst_i ^ flush_i;
   end else begin : g_pipe
      localparam int unsigned N = NumPipeRegs;

      logic [N-1:0]        valid_s;
      logic [N-1:0]        ready_s;
      logic [Width-1:0]    result_s [N];
      logic [4:0]          status_s [N];
      logic [TagWidth-1:0] tag_s    [N];

      // Backpressure ripples from the output towards stage 0
      always_comb begin
         logic chain_v;
         ready_s = '0;
         chain_v = out_ready_i;
         for (int k = int'(N) - 1; k >= 0; k--) begin
            ready_s[k] = chain_v | ~valid_s[k];
            chain_v    = ready_s[k];
         end
      end

      for (genvar k = 0; k < N; k++) begin : g_stage
         logic                up_valid_s;
         logic [Width-1:0]    up_result_s;
         logic [4:0]          up_status_s;
         logic [TagWidth-1:0] up_tag_s;
         logic                valid_r;
         logic [Width-1:0]    result_r;
         logic [4:0]          status_r;
         logic [TagWidth-1:0] tag_r;

         if (k == 0) begin : g_head
            assign up_valid_s  = in_valid_i;
            assign up_result_s = in_result_i;
            assign up_status_s = in_status_i;
            assign up_tag_s    = in_tag_i;
         end else begin : g_body
            assign up_valid_s  = valid_s[k-1];
            assign up_result_s = result_s[k-1];
            assign up_status_s = status_s[k-1];
            assign up_tag_s    = tag_s[k-1];
         end

         // Valid bit: flush wins over any advance in the same cycle
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               valid_r <= 1'b0;
            end else if (flush_i) begin
               valid_r <= 1'b0;
            end else if (ready_s[k]) begin
               valid_r <= up_valid_s;
            end else begin
               valid_r <= valid_r;
            end
         end

         // Payload: loads only on an accepted upstream entry, untouched by flush
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               result_r <= {Width{1'b0}};
               status_r <= 5'b00000;
               tag_r    <= {TagWidth{1'b0}};
            end else if (ready_s[k] && up_valid_s) begin
               result_r <= up_result_s;
               status_r <= up_status_s;
               tag_r    <= up_tag_s;
            end else begin
               result_r <= result_r;
               status_r <= status_r;
               tag_r    <= tag_r;
            end
         end

         assign valid_s[k]  = valid_r;
         assign result_s[k] = result_r;
         assign status_s[k] = status_r;
         assign tag_s[k]    = tag_r;
      end

      assign in_ready_o   = ready_s[0];
      assign out_valid_o  = valid_s[N-1];
      assign out_result_o = result_s[N-1];
      assign out_status_o = status_s[N-1];
      assign out_tag_o    = tag_s[N-1];
      assign busy_o       = |valid_s;
   end

endmodule
